// File: rtl/decoder8_stream.sv
// Streaming binary-to-one-hot decoder behind a 2-entry elastic buffer.
// Codes are buffered, and only the head entry is decoded on the way out.
module decoder8_stream #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                ASYNCRESETN,
    input  logic [N-1:0]        I,
    input  logic                I_valid,
    output logic                I_ready,
    output logic [(2**N)-1:0]   O,
    output logic                O_valid,
    input  logic                O_ready,
    output logic [CNT_W-1:0]    beats
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high.
    // The sender holds its payload stable while valid && !ready, and it keeps valid
    // asserted until the transfer happens. I_ready depends only on registered state.

    logic [N-1:0] mem [2];
    logic         head;
    logic         tail;
    logic [1:0]   occ;
    logic [1:0]   occ_next;
    logic         push;
    logic         pop;
    logic [(2**N)-1:0] one;

    assign one     = {{((2**N)-1){1'b0}}, 1'b1};
    assign I_ready = (occ != 2'd2);
    assign O_valid = (occ != 2'd0);
    assign push    = I_valid && I_ready;
    assign pop     = O_valid && O_ready;
    assign O       = O_valid ? (one << mem[head]) : '0;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= 2'd0;
            beats  <= '0;
        end else begin
            occ <= occ_next;
            if (push) begin
                mem[tail] <= I;
                tail      <= ~tail;
            end
            if (pop) begin
                head  <= ~head;
                beats <= beats + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder8_stream.sv
// Directed bench for decoder8_stream: a vector table with hand-computed outputs,
// plus sequences for asynchronous reset and an exp_q-scored counter-wrap run.
module tb_decoder8_stream;

    logic       clk;
    logic       rst_n;
    logic [2:0] code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] beats;

    int checks = 0;
    int errors = 0;

    decoder8_stream #(.N(3), .CNT_W(8)) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .I           (code),
        .I_valid     (in_valid),
        .I_ready     (in_ready),
        .O           (out_data),
        .O_valid     (out_valid),
        .O_ready     (out_ready),
        .beats       (beats)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] code;
        logic       vld;
        logic       ordy;
        logic [7:0] exp_o;
        logic       exp_ov;
        logic       exp_ir;
        logic [7:0] exp_beats;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: inputs change just after a rising edge
    task automatic drive(input logic [2:0] c, input logic v, input logic r);
        code      = c;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        int pushed;
        logic model_push;
        logic model_pop;

        drive(3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        check("reset_o", {24'd0, out_data}, 32'h00);
        check("reset_ov", {31'd0, out_valid}, 32'd0);
        check("reset_ir", {31'd0, in_ready}, 32'd1);
        check("reset_beats", {24'd0, beats}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // exhaustive decode with O_ready high
        for (int i = 0; i < 8; i++) begin
            logic [7:0] eo;
            eo = (i == 0) ? 8'h00 : (8'h01 << (i - 1));
            vecs.push_back('{i[2:0], 1'b1, 1'b1, eo, (i != 0), 1'b1, (i == 0) ? 8'd0 : 8'(i - 1)});
        end
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 8'd7});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd8});
        // back-pressure: 3,5 accepted, 6 held until space frees
        vecs.push_back('{3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd8});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 8'h08, 1'b1, 1'b1, 8'd8});
        vecs.push_back('{3'd6, 1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 8'd8});
        vecs.push_back('{3'd6, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0, 8'd8});
        vecs.push_back('{3'd6, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 8'd9});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 8'd10});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd11});
        // simultaneous push/pop at occupancy 1
        vecs.push_back('{3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd11});
        vecs.push_back('{3'd7, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 8'd11});
        vecs.push_back('{3'd0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 8'd12});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 8'd12});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd13});
        // full with O_ready high: no push that edge, code 1 taken on the next
        vecs.push_back('{3'd4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd13});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'd13});
        vecs.push_back('{3'd1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'd13});
        vecs.push_back('{3'd1, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 8'd14});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 8'd14});
        vecs.push_back('{3'd0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd15});
        vecs.push_back('{3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd16});

        foreach (vecs[k]) begin
            drive(vecs[k].code, vecs[k].vld, vecs[k].ordy);
            @(negedge clk);
            check($sformatf("vec%0d_o", k), {24'd0, out_data}, {24'd0, vecs[k].exp_o});
            check($sformatf("vec%0d_ov", k), {31'd0, out_valid}, {31'd0, vecs[k].exp_ov});
            check($sformatf("vec%0d_ir", k), {31'd0, in_ready}, {31'd0, vecs[k].exp_ir});
            check($sformatf("vec%0d_beats", k), {24'd0, beats}, {24'd0, vecs[k].exp_beats});
            next_cycle();
        end

        // asynchronous reset mid-cycle with two entries held
        drive(3'd3, 1'b1, 1'b0);
        next_cycle();
        drive(3'd6, 1'b1, 1'b0);
        next_cycle();
        drive(3'd0, 1'b0, 1'b0);
        check("full_o", {24'd0, out_data}, 32'h08);
        check("full_ir", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_o", {24'd0, out_data}, 32'h00);
        check("async_ov", {31'd0, out_valid}, 32'd0);
        check("async_ir", {31'd0, in_ready}, 32'd1);
        check("async_beats", {24'd0, beats}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("idle_o", {24'd0, out_data}, 32'h00);
            check("idle_ov", {31'd0, out_valid}, 32'd0);
            check("idle_ir", {31'd0, in_ready}, 32'd1);
            check("idle_beats", {24'd0, beats}, 32'd0);
            next_cycle();
        end

        // counter wrap: 257 beats scored against exp_q
        pushed = 0;
        cycles = 0;
        while ((pushed < 257 || exp_q.size() != 0) && cycles < 400) begin
            drive(3'(pushed % 8), (pushed < 257), 1'b1);
            @(negedge clk);
            check("wrap_ir", {31'd0, in_ready}, {31'd0, (exp_q.size() != 2)});
            check("wrap_ov", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
            if (exp_q.size() != 0)
                check("wrap_o", {24'd0, out_data}, 32'h1 << exp_q[0]);
            model_push = in_valid && (exp_q.size() != 2);
            model_pop  = (exp_q.size() != 0) && out_ready;
            next_cycle();
            if (model_pop)
                void'(exp_q.pop_front());
            if (model_push) begin
                exp_q.push_back(code);
                pushed++;
            end
            cycles++;
        end
        if (cycles >= 400)
            check("wrap_timeout", 32'(cycles), 32'd0);
        drive(3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_beats", {24'd0, beats}, 32'd1);
        check("wrap_empty_ov", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder8_stream.md
# decoder8_stream

Streaming 3-to-8 binary-to-one-hot decoder with a valid/ready handshake on both sides and a 2-entry elastic buffer between them. It is the receive-side counterpart of the 8-input encoder. An incoming 3-bit code is returned to its one-hot form, and the buffer absorbs one cycle of downstream back-pressure without losing a beat. A wrapping beat counter gives the bench and the debug logic visibility of throughput.

## Interface
- N, default 3: code width; the one-hot output is 2^N bits wide (8 at default).
- CNT_W, default 8: width of the delivered-beat counter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- I  input  N  binary code to decode.
- I_valid  input  1  upstream offers I this cycle.
- I_ready  output  1  block can accept a beat this cycle.
- O  output  2^N  one-hot decode of the head entry; all zeros when the buffer is empty.
- O_valid  output  1  head entry is presented on O.
- O_ready  input  1  downstream accepts O this cycle.
- beats  output  CNT_W  count of beats delivered downstream, modulo 2^CNT_W.

## Operation
- Storage is a 2-entry FIFO of N-bit codes: head pointer, tail pointer and a 2-bit occupancy register (0, 1 or 2). Codes are stored, not one-hots; decoding happens on the head entry at the output.
- Push: I_valid && I_ready at the rising edge. The code is written at the tail and the tail advances, wrapping 1→0.
- Pop: O_valid && O_ready at the rising edge. The head advances, wrapping 1→0, and beats increments, wrapping from 2^CNT_W−1 to 0.
- I_ready = (occupancy != 2). It is a function of registered state only and has no combinational path from O_ready.
- O_valid = (occupancy != 0).
- O = (1 << head_code) when O_valid, else all zeros. Exactly one bit is set whenever O_valid=1; every code value 0..2^N−1 is legal.
- Occupancy update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged; FIFO order is preserved.
  - neither: unchanged.
- Full (2): I_ready=0, so no push can occur, even if O_ready=1 in the same cycle. There is no pass-through.
- Empty (0): O_valid=0 and O=0; O_ready is ignored.
- Both handshake sides obey standard rules:
  - Upstream holds I stable while I_valid && !I_ready.
  - The block holds O and O_valid stable while O_valid && !O_ready.
  - O_valid never deasserts without a pop.
- Reset while ASYNCRESETN=0, asserted at any time including mid-transfer:
  - occupancy, head, tail and beats clear to 0 immediately, independent of CLK.
  - Buffered codes are discarded.
  - Outputs: O_valid=0, O=0, I_ready=1, beats=0.
  - Normal operation resumes at the first rising edge after deassertion.

## Timing
- Latency: a code pushed at edge k is visible on O, with O_valid=1, after edge k if the buffer was empty before that edge.
- Throughput: 1 beat/cycle sustained when O_ready is held at 1.
- One stall cycle of O_ready=0 is absorbed: occupancy goes to 2 and I_ready drops after that edge.
- Outputs O, O_valid, I_ready and beats are decoded from registers only. No input-to-output combinational path exists.
- Reset values: O=0, O_valid=0, I_ready=1, beats=0.

## Test plan
- Reset/idle: assert ASYNCRESETN=0 mid-cycle with 2 entries held.
  - Required, immediately: O_valid=0, O=8'h00, I_ready=1, beats=0.
  - After release with I_valid=0: outputs unchanged.
- Exhaustive decode: stream codes 0..7 back-to-back with O_ready=1.
  - Required: O = 01,02,04,08,10,20,40,80 on consecutive cycles, each one cycle after its push.
  - Required: beats=8 at the end.
- Back-pressure: push 3, 5, 6 on consecutive cycles with O_ready=0.
  - Required: accepted are 3 and 5; I_ready=0 from the cycle after the second push, and 6 is held by upstream.
  - Then raise O_ready=1. Required output order: 08, 20, 40, with no beat lost or duplicated.
- Simultaneous push/pop at occupancy 1 (head=2), push code 7 with O_ready=1.
  - Required: occupancy stays 1; O changes from 04 to 80 on the next cycle.
- Full with O_ready=1: occupancy 2, I_valid=1 with code 1, O_ready=1.
  - Required: no push that cycle (I_ready=0) and occupancy becomes 1.
  - Required: code 1 is accepted on the following edge.
- Counter wrap, CNT_W=8: deliver 257 beats. Required: beats=1.
